mc_control_fsm: RTL

- Multicycle MIPS control unit. It decodes opcode/funct from the instruction register and sequences one instruction over 3–5 states.
- It produces the 4-bit alu_ctrl word that the ALU consumes, together with datapath enables and the PC write decision. The PC write decision uses the ALU's flag_zero.
- It sits between the IR/memory interface and the datapath.
- Memory accesses use a req/ready handshake, so variable-latency memory stalls the FSM.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mc_control_fsm_alu_op_decode.sv | 68 ++++++
 rtl/mc_control_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the multicycle MIPS control path.
//   ALU_CTRL_*  : 4-bit ALU operation codes consumed by the ALU
//   OP_*        : IR[31:26] opcode values decoded by the control FSM
//   FN_*        : IR[5:0] funct values for R-type instructions
//   state_t     : control FSM state encoding
//   alu_class_t : which rule selects alu_ctrl in the current state
package mips_pkg;

    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0011;
    localparam logic [3:0] ALU_CTRL_MUL = 4'b0100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_MUL = 6'h18;

    typedef enum logic [3:0] {
        RST_IDLE,
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADDR,    // address/PC arithmetic: always ADD
        CLS_RTYPE,   // operation chosen by funct
        CLS_ITYPE,   // operation chosen by opcode
        CLS_BRANCH   // equality compare: SUB
    } alu_class_t;

endpackage

// File: rtl/mc_control_fsm_alu_op_decode.sv
// alu_op_decode: pure combinational opcode/funct/class -> alu_ctrl mapping,
// plus legality of the instruction held in IR.
//   opcode   in  6  IR[31:26]
//   funct    in  6  IR[5:0]
//   op_class in  2  selection rule for the current control state
//   alu_ctrl out 4  ALU operation code
//   illegal  out 1  opcode undecoded, or R-type with undecoded funct
module alu_op_decode
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  alu_class_t  op_class,
    output logic [3:0]  alu_ctrl,
    output logic        illegal
);

    logic [3:0] rtype_ctrl;
    logic       rtype_ok;
    logic [3:0] itype_ctrl;
    logic       op_ok;

    always_comb begin
        rtype_ctrl = ALU_CTRL_ADD;
        rtype_ok   = 1'b1;
        case (funct)
            FN_AND:  rtype_ctrl = ALU_CTRL_AND;
            FN_OR:   rtype_ctrl = ALU_CTRL_OR;
            FN_ADD:  rtype_ctrl = ALU_CTRL_ADD;
            FN_SUB:  rtype_ctrl = ALU_CTRL_SUB;
            FN_MUL:  rtype_ctrl = ALU_CTRL_MUL;
            default: rtype_ok   = 1'b0;
        endcase
    end

    always_comb begin
        itype_ctrl = ALU_CTRL_ADD;
        case (opcode)
            OP_ANDI: itype_ctrl = ALU_CTRL_AND;
            OP_ORI:  itype_ctrl = ALU_CTRL_OR;
            default: itype_ctrl = ALU_CTRL_ADD;
        endcase
    end

    always_comb begin
        op_ok = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_ok = 1'b1;
            default:                        op_ok = 1'b0;
        endcase
    end

    // funct only matters for R-type; other opcodes reuse those bits as imm
    assign illegal = !op_ok || ((opcode == OP_RTYPE) && !rtype_ok);

    always_comb begin
        alu_ctrl = ALU_CTRL_ADD;
        case (op_class)
            CLS_ADDR:   alu_ctrl = ALU_CTRL_ADD;
            CLS_RTYPE:  alu_ctrl = rtype_ctrl;
            CLS_ITYPE:  alu_ctrl = itype_ctrl;
            CLS_BRANCH: alu_ctrl = ALU_CTRL_SUB;
            default:    alu_ctrl = ALU_CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit. Sequences one instruction
// through 3-5 states, stalling on the memory req/ready handshake.
// Optional macro MC_CONTROL_PERF_EN adds perf_cycles/perf_instrs counters.
//   clk, rst       clock, synchronous active-high reset
//   opcode, funct  IR fields
//   flag_zero      ALU zero flag (branch decision)
//   mem_ready      memory handshake completion
//   mem_req/mem_we/iord                 memory interface controls
//   ir_write/reg_write/reg_dst/mem_to_reg datapath write controls
//   alu_src_a/alu_src_b/alu_ctrl        ALU operand and operation select
//   pc_source/pc_en                     PC update
//   instr_done     one-cycle pulse on the last state of an instruction
//   halted         high in HALT
//   perf_cycles/perf_instrs (MC_CONTROL_PERF_EN only)
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter bit          ILLEGAL_HALT = 1'b1,
    parameter int unsigned ALU_CTRL_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  flag_zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  iord,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [1:0]            pc_source,
    output logic                  pc_en,
    output logic                  instr_done,
    output logic                  halted
`ifdef MC_CONTROL_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_instrs
`endif
);

    state_t     state;
    alu_class_t op_class;
    logic [3:0] dec_ctrl;
    logic       illegal;
    logic       use_alu;

    alu_op_decode u_alu_op_decode (
        .opcode   (opcode),
        .funct    (funct),
        .op_class (op_class),
        .alu_ctrl (dec_ctrl),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_IDLE;
        end else begin
            case (state)
                RST_IDLE: state <= FETCH;
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    if (illegal) begin
                        state <= ILLEGAL_HALT ? HALT : FETCH;
                    end else begin
                        case (opcode)
                            OP_RTYPE:               state <= EXEC_R;
                            OP_LW, OP_SW:           state <= MEM_ADDR;
                            OP_BEQ:                 state <= BRANCH;
                            OP_ADDI, OP_ANDI, OP_ORI: state <= EXEC_I;
                            default:                state <= JUMP;
                        endcase
                    end
                end
                EXEC_R, EXEC_I: state <= ALU_WB;
                ALU_WB:   state <= FETCH;
                MEM_ADDR: state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   if (mem_ready) state <= MEM_WB;
                MEM_WB:   state <= FETCH;
                MEM_WR:   if (mem_ready) state <= FETCH;
                BRANCH, JUMP: state <= FETCH;
                HALT:     state <= HALT;
                default:  state <= RST_IDLE;
            endcase
        end
    end

    // Outputs follow the state register; ir_write/pc_en in FETCH and
    // instr_done in MEM_WR additionally qualify on mem_ready.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        pc_source  = 2'd0;
        pc_en      = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        op_class   = CLS_ADDR;
        use_alu    = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                use_alu   = 1'b1;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE: begin
                alu_src_b  = 2'd3;
                use_alu    = 1'b1;
                instr_done = illegal && !ILLEGAL_HALT;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                op_class  = CLS_RTYPE;
                use_alu   = 1'b1;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                op_class  = CLS_ITYPE;
                use_alu   = 1'b1;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                instr_done = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                use_alu   = 1'b1;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                op_class   = CLS_BRANCH;
                use_alu    = 1'b1;
                pc_source  = 2'd1;
                pc_en      = flag_zero;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_source  = 2'd2;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // alu_ctrl is forced to AND (all zeros) in states that do not use the ALU
    assign alu_ctrl = use_alu ? dec_ctrl : '0;

`ifdef MC_CONTROL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_instrs <= '0;
        end else begin
            if (state != RST_IDLE && state != HALT) perf_cycles <= perf_cycles + 32'd1;
            if (instr_done) perf_instrs <= perf_instrs + 32'd1;
        end
    end
`endif

endmodule
